// File: rtl/testability_profiler.sv
// Random-pattern testability profiler: LFSR stimulus, per-net hit counters.
// Optional MISR response compaction when TP_MISR_EN is defined.
module testability_profiler #(
  parameter int             PAT_W     = 16,
  parameter int             NCH       = 4,
  parameter int             CNT_W     = 16,
  parameter int             NPAT_W    = 20,
  parameter logic [PAT_W-1:0] LFSR_POLY = 16'hB400,
  parameter logic [PAT_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NPAT_W-1:0]    num_patterns,
  output logic [PAT_W-1:0]     pattern_out,
  input  logic [NCH-1:0]       obs_in,
  output logic                 busy,
  output logic                 done,
  output logic [NCH*CNT_W-1:0] hit_cnt,
  output logic [NCH-1:0]       sat,
  output logic [PAT_W-1:0]     signature
);

  if (NCH < 1 || NCH > PAT_W) begin : g_bad_nch
    $error("testability_profiler: NCH must be in 1..PAT_W");
  end

  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [PAT_W-1:0] SEED =
    (LFSR_SEED == '0) ? PAT_W'(1) : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [NPAT_W-1:0]         remaining;
  logic [PAT_W-1:0]          lfsr;
  logic [NCH-1:0][CNT_W-1:0] cnt;
  logic                      accept;

  function automatic logic [PAT_W-1:0] step(
    input logic [PAT_W-1:0] s
  );
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  assign accept      = (state_q == IDLE) && start;
  assign pattern_out = lfsr;
  assign hit_cnt     = cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (num_patterns != '0) ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (remaining == NPAT_W'(1))
          state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern generator, run length and saturating hit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      lfsr      <= SEED;
      cnt       <= '0;
      sat       <= '0;
    end else if (accept) begin
      remaining <= num_patterns;
      lfsr      <= SEED;
      cnt       <= '0;
      sat       <= '0;
    end else if (state_q == RUN) begin
      remaining <= remaining - NPAT_W'(1);
      lfsr      <= step(lfsr);
      for (int k = 0; k < NCH; k++) begin
        if (obs_in[k]) begin
          if (&cnt[k]) sat[k] <= 1'b1;
          else         cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

`ifdef TP_MISR_EN
  logic [PAT_W-1:0] misr;

  // Response compactor sharing the stimulus polynomial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misr <= '0;
    else if (accept)
      misr <= '0;
    else if (state_q == RUN)
      misr <= step(misr) ^ PAT_W'(obs_in);
  end

  assign signature = misr;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_testability_profiler.sv
// Directed bench for testability_profiler with immediate-assertion checks.
// Covers reset, run length, zero-length run, saturation, LFSR model, aborts.
module tb_testability_profiler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [19:0] num;
  logic        mode;
  logic [3:0]  obs_reg;
  logic [3:0]  obs;
  logic [15:0] pat;
  logic        busy;
  logic        done;
  logic [63:0] hits;
  logic [3:0]  sat;
  logic [15:0] sig;

  logic        start4;
  logic [19:0] num4;
  logic [3:0]  obs4;
  logic [15:0] pat4;
  logic        busy4;
  logic        done4;
  logic [15:0] hits4;
  logic [3:0]  sat4;
  logic [15:0] sig4;

  int n_assert = 0;
  int n_fail   = 0;

  assign obs = mode ? pat[3:0] : obs_reg;

  testability_profiler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_patterns (num),
    .pattern_out  (pat),
    .obs_in       (obs),
    .busy         (busy),
    .done         (done),
    .hit_cnt      (hits),
    .sat          (sat),
    .signature    (sig)
  );

  testability_profiler #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start4),
    .num_patterns (num4),
    .pattern_out  (pat4),
    .obs_in       (obs4),
    .busy         (busy4),
    .done         (done4),
    .hit_cnt      (hits4),
    .sat          (sat4),
    .signature    (sig4)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step16(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until done (bounded), returning the number of busy cycles seen.
  task automatic wait_done(input int bound, output int nbusy);
    int g;
    nbusy = 0;
    g = 0;
    while (!done && g < bound) begin
      if (busy) nbusy++;
      tick();
      g++;
    end
  endtask

  task automatic run(input logic [19:0] n);
    num   = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int          nb;
  int          ndone;
  int          g;
  logic [15:0] s;
  logic [15:0] m;
  int          mc [4];

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    num     = '0;
    mode    = 1'b0;
    obs_reg = 4'b0000;
    start4  = 1'b0;
    num4    = '0;
    obs4    = 4'b1111;

    // Asynchronous reset asserted mid-cycle.
    #12 rst_n = 1'b0;
    #1;
    check("rst_pattern", 32'(pat), 32'hACE1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hits", 32'(hits[31:0]), 32'd0);
    check("rst_hits_hi", 32'(hits[63:32]), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_sig", 32'(sig), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Ten patterns, channel 0 held high.
    obs_reg = 4'b0001;
    run(20'd10);
    check("run10_busy_rise", 32'(busy), 32'd1);
    wait_done(50, nb);
    check("run10_busy_cycles", 32'(nb), 32'd10);
    check("run10_done", 32'(done), 32'd1);
    check("run10_busy_at_done", 32'(busy), 32'd0);
    check("run10_ch0", 32'(hits[15:0]), 32'd10);
    check("run10_ch1", 32'(hits[31:16]), 32'd0);
    check("run10_ch2", 32'(hits[47:32]), 32'd0);
    check("run10_ch3", 32'(hits[63:48]), 32'd0);
    check("run10_sat", 32'(sat), 32'd0);
    tick();
    check("run10_done_pulse", 32'(done), 32'd0);
    check("run10_hold", 32'(hits[15:0]), 32'd10);

    // Zero-length run goes straight to DONE.
    obs_reg = 4'b1111;
    run(20'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_hits", 32'(hits[31:0]), 32'd0);
    check("zero_hits_hi", 32'(hits[63:32]), 32'd0);
    tick();
    check("zero_done_off", 32'(done), 32'd0);

    // Narrow counters saturate and stick.
    num4   = 20'd20;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    g = 0;
    while (!done4 && g < 60) begin
      tick();
      g++;
    end
    check("sat_done", 32'(done4), 32'd1);
    check("sat_hits", 32'(hits4), 32'hFFFF);
    check("sat_flags", 32'(sat4), 32'hF);

    // Counts against the bench LFSR model, twice.
    mode = 1'b1;
    for (int k = 0; k < 4; k++) mc[k] = 0;
    s = 16'hACE1;
    m = 16'h0000;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 4; k++) if (s[k]) mc[k]++;
      m = step16(m) ^ {12'h000, s[3:0]};
      s = step16(s);
    end
    for (int r = 0; r < 2; r++) begin
      run(20'd1000);
      wait_done(1100, nb);
      check("lfsr_busy_cycles", 32'(nb), 32'd1000);
      check("lfsr_ch0", 32'(hits[15:0]), 32'(mc[0]));
      check("lfsr_ch1", 32'(hits[31:16]), 32'(mc[1]));
      check("lfsr_ch2", 32'(hits[47:32]), 32'(mc[2]));
      check("lfsr_ch3", 32'(hits[63:48]), 32'(mc[3]));
      check("lfsr_final_pat", 32'(pat), 32'(s));
`ifdef TP_MISR_EN
      check("lfsr_sig", 32'(sig), 32'(m));
`else
      check("lfsr_sig", 32'(sig), 32'd0);
`endif
      tick();
    end
    mode = 1'b0;

    // start during RUN and DONE is ignored.
    obs_reg = 4'b0001;
    run(20'd10);
    tick();
    tick();
    num   = 20'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50, nb);
    check("ign_run_done", 32'(done), 32'd1);
    check("ign_run_ch0", 32'(hits[15:0]), 32'd10);
    num   = 20'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ign_done_busy", 32'(busy), 32'd0);
    check("ign_done_ch0", 32'(hits[15:0]), 32'd10);

    // Reset at RUN cycle 5 aborts without done.
    run(20'd10);
    for (int i = 0; i < 4; i++) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hits", 32'(hits[15:0]), 32'd0);
    check("abort_pat", 32'(pat), 32'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run(20'd7);
    wait_done(50, nb);
    check("fresh_busy_cycles", 32'(nb), 32'd7);
    check("fresh_done", 32'(done), 32'd1);
    check("fresh_ch0", 32'(hits[15:0]), 32'd7);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
